// File: rtl/pingpong_counter_pkg.sv
// counter_pkg: shared types and constants for the pingpong_counter slice.
//   mode_t        - counting mode (UP, DOWN, PINGPONG, HOLD)
//   DEFAULT_WIDTH - default counter width in bits
package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_t;

endpackage

// File: rtl/pingpong_counter_if.sv
// pingpong_counter_if: control/status bundle between a counter and its user.
//   master: drives en, mode, lo, hi, load, load_val (and step); sees n, forward, wrap
//   slave : the counter side of the same signals
// Optional macro: PINGPONG_COUNTER_STEP_EN adds the step signal.
interface pingpong_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef PINGPONG_COUNTER_STEP_EN
  logic [WIDTH-1:0] step;
`endif
  logic [WIDTH-1:0] n;
  logic             forward;
  logic             wrap;

`ifdef PINGPONG_COUNTER_STEP_EN
  modport master (output en, mode, lo, hi, load, load_val, step,
                  input  n, forward, wrap);
  modport slave  (input  en, mode, lo, hi, load, load_val, step,
                  output n, forward, wrap);
`else
  modport master (output en, mode, lo, hi, load, load_val,
                  input  n, forward, wrap);
  modport slave  (input  en, mode, lo, hi, load, load_val,
                  output n, forward, wrap);
`endif

endinterface

// File: rtl/pingpong_counter_next.sv
// pingpong_counter_next: combinational next-state for one enabled count step.
//   n_i, fwd_i     - current count and direction
//   mode_i         - counting mode
//   lo_i, hi_i     - inclusive bounds
//   step_i         - step size
//   n_o, fwd_o     - next count and direction
//   wrap_o         - wrap/turnaround flag for this step
// All bound compares are WIDTH+1 bits wide so n+step and lo+step cannot overflow.
module pingpong_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] n_i,
  input  logic             fwd_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] n_o,
  output logic             fwd_o,
  output logic             wrap_o
);

  logic [WIDTH:0]   n_x, lo_x, hi_x, s_x;
  logic [WIDTH:0]   n_ps, lo_ps;
  logic [WIDTH-1:0] n_ms;
  logic             oor;

  assign n_x   = {1'b0, n_i};
  assign lo_x  = {1'b0, lo_i};
  assign hi_x  = {1'b0, hi_i};
  assign s_x   = {1'b0, step_i};
  assign n_ps  = n_x + s_x;
  assign lo_ps = lo_x + s_x;
  // Only used when n >= lo+step, so it never underflows.
  assign n_ms  = n_i - step_i;
  // Inverted bounds always land here too: any n is then below lo or above hi.
  assign oor   = (n_x < lo_x) || (n_x > hi_x) || (lo_x > hi_x);

  // step == 0 needs no special case: no compare can trip, so n holds, wrap = 0.
  always_comb begin
    n_o    = n_i;
    fwd_o  = fwd_i;
    wrap_o = 1'b0;
    if (oor) begin
      n_o   = lo_i;
      fwd_o = 1'b1;
    end else begin
      case (mode_i)
        MODE_UP: begin
          fwd_o = 1'b1;
          if (n_ps > hi_x) begin
            n_o    = lo_i;
            wrap_o = 1'b1;
          end else begin
            n_o = n_ps[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          fwd_o = 1'b0;
          if (n_x < lo_ps) begin
            n_o    = hi_i;
            wrap_o = 1'b1;
          end else begin
            n_o = n_ms;
          end
        end
        MODE_PINGPONG: begin
          if (fwd_i) begin
            if (n_ps > hi_x) begin
              // Turn around without dwelling on hi.
              fwd_o  = 1'b0;
              wrap_o = 1'b1;
              n_o    = (n_x >= lo_ps) ? n_ms : lo_i;
            end else begin
              n_o = n_ps[WIDTH-1:0];
            end
          end else begin
            if (n_x < lo_ps) begin
              fwd_o  = 1'b1;
              wrap_o = 1'b1;
              n_o    = (n_ps <= hi_x) ? n_ps[WIDTH-1:0] : hi_i;
            end else begin
              n_o = n_ms;
            end
          end
        end
        default: ; // HOLD
      endcase
    end
  end

endmodule

// File: rtl/pingpong_counter.sv
// pingpong_counter: bounded up/down/ping-pong counter with load and wrap pulse.
//   clk   - clock, all state on posedge
//   reset - synchronous active-high reset
//   bus   - pingpong_counter_if.slave: en, mode, lo, hi, load, load_val,
//           [step], n, forward, wrap
// Optional macro: PINGPONG_COUNTER_STEP_EN takes the step from bus.step;
// otherwise the step is fixed at 1.
// Holds the registers and the reset > load > en priority; the step
// arithmetic lives in pingpong_counter_next.
module pingpong_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  pingpong_counter_if.slave bus
);

  logic [WIDTH-1:0] n_q, n_d, n_nx, step_w;
  logic             fwd_q, fwd_d, fwd_nx;
  logic             wrap_q, wrap_d, wrap_nx;

`ifdef PINGPONG_COUNTER_STEP_EN
  assign step_w = bus.step;
`else
  assign step_w = WIDTH'(1);
`endif

  pingpong_counter_next #(.WIDTH(WIDTH)) u_next (
    .n_i    (n_q),
    .fwd_i  (fwd_q),
    .mode_i (bus.mode),
    .lo_i   (bus.lo),
    .hi_i   (bus.hi),
    .step_i (step_w),
    .n_o    (n_nx),
    .fwd_o  (fwd_nx),
    .wrap_o (wrap_nx)
  );

  always_comb begin
    n_d    = n_q;
    fwd_d  = fwd_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      n_d = bus.load_val;
    end else if (bus.en) begin
      n_d    = n_nx;
      fwd_d  = fwd_nx;
      wrap_d = wrap_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q    <= '0;
      fwd_q  <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      fwd_q  <= fwd_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.n       = n_q;
  assign bus.forward = fwd_q;
  assign bus.wrap    = wrap_q;

endmodule
